// File: rtl/core_node_pkg.sv
// ----------------------------------------------------------------------------
// core_node_pkg
// Shared definitions for the node position store.
//   - Field offsets of the four words that make up one node entry in the
//     flattened store bus (x, y, previous x, previous y).
//   - State encoding of the result writer FSM.
// ----------------------------------------------------------------------------
package core_node_pkg;

   localparam int FLD_X           = 0;
   localparam int FLD_Y           = 1;
   localparam int FLD_PRE_X       = 2;
   localparam int FLD_PRE_Y       = 3;
   localparam int FIELDS_PER_NODE = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      WRITE  = 2'd2
   } wr_state_t;

endpackage : core_node_pkg

// File: rtl/core_node_index_encoder.sv
// ----------------------------------------------------------------------------
// core_node_index_encoder
// Combinational priority encoder for the node selector.
//   sel        in   node_contains  low selector bits, one bit per node
//   index      out  IDX_W          position of the lowest set bit (0 if none)
//   any_set    out  1              at least one bit of sel is set
//   onehot_ok  out  1              exactly one bit of sel is set
// ----------------------------------------------------------------------------
module core_node_index_encoder #(
   parameter int node_contains = 5,
   localparam int IDX_W = (node_contains > 1) ? $clog2(node_contains) : 1
) (
   input  logic [node_contains-1:0] sel,
   output logic [IDX_W-1:0]         index,
   output logic                     any_set,
   output logic                     onehot_ok
);

   // Scan from the top down so the lowest set bit is the last one assigned.
   // NOTE: index gets a default before the loop so no path leaves it
   // unassigned; otherwise a latch is inferred.
   always_comb begin
      index = '0;
      for (int i = node_contains - 1; i >= 0; i--) begin
         if (sel[i]) begin
            index = IDX_W'(i);
         end
      end
   end

   assign any_set   = |sel;
   // Clearing the lowest set bit leaves zero only when a single bit was set.
   assign onehot_ok = any_set && ((sel & (sel - node_contains'(1))) == '0);

endmodule : core_node_index_encoder

// File: rtl/core_alu_result_writer.sv
// ----------------------------------------------------------------------------
// core_alu_result_writer
// Owns the node position store and writes ALU results back into it. One
// result is accepted per handshake; the selected node's current position is
// shifted into its previous-position fields and replaced by the new one
// (or, on an initial load, all four words take the new value).
//
//   clk          in   1                         system clock, rising edge
//   rst_n        in   1                         async active-low reset
//   wr_valid     in   1                         result present
//   wr_ready     out  1                         can accept (IDLE only)
//   v_selector   in   width                     one-hot node select
//   new_x        in   width                     new x position
//   new_y        in   width                     new y position
//   init_en      in   1                         initial load of history fields
//   ram_flatted  out  width*4*node_contains     store, node i word k at
//                                               [(i*4+k)*width +: width]
//   wr_done      out  1                         one-cycle completion pulse
//   wr_error     out  1                         qualifies wr_done: rejected
//   busy         out  1                         state != IDLE
//
// Configuration macro CORE_WB_ONEHOT_CHECK_EN:
//   defined   - selectors with zero or several low bits set are rejected
//               (no write, wr_error with wr_done).
//   undefined - lowest set bit wins, zero selector writes nothing,
//               wr_error is tied low.
// ----------------------------------------------------------------------------
module core_alu_result_writer
   import core_node_pkg::*;
#(
   parameter int width         = 32,
   parameter int node_contains = 5
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       wr_valid,
   output logic                                       wr_ready,
   input  logic [width-1:0]                           v_selector,
   input  logic [width-1:0]                           new_x,
   input  logic [width-1:0]                           new_y,
   input  logic                                       init_en,
   output logic [width*FIELDS_PER_NODE*node_contains-1:0] ram_flatted,
   output logic                                       wr_done,
   output logic                                       wr_error,
   output logic                                       busy
);

   localparam int IDX_W = (node_contains > 1) ? $clog2(node_contains) : 1;

   wr_state_t state_q, state_d;
   logic      accept;

   // Holding registers, stable from accept until the return to IDLE.
   logic [node_contains-1:0] sel_q;
   logic [width-1:0]         x_q, y_q;
   logic                     init_q;

   // Decoded target, registered in DECODE.
   logic [IDX_W-1:0]         idx_q;
   logic                     valid_q;

   logic [IDX_W-1:0]         enc_index;
   logic                     enc_any_set;
   logic                     enc_onehot_ok;
   logic                     target_valid;

   logic [width-1:0] store_q [node_contains][FIELDS_PER_NODE];

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // wr_ready/busy depend on the state register only; wr_valid only steers
   // the next state.
   always_comb begin
      state_d  = state_q;
      wr_ready = 1'b0;
      busy     = 1'b1;
      accept   = 1'b0;
      case (state_q)
         IDLE: begin
            wr_ready = 1'b1;
            busy     = 1'b0;
            accept   = wr_valid;
            if (wr_valid) begin
               state_d = DECODE;
            end
         end
         DECODE:  state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Index decode
   // -------------------------------------------------------------------------
   core_node_index_encoder #(
      .node_contains (node_contains)
   ) u_index_encoder (
      .sel       (sel_q),
      .index     (enc_index),
      .any_set   (enc_any_set),
      .onehot_ok (enc_onehot_ok)
   );

`ifdef CORE_WB_ONEHOT_CHECK_EN
   assign target_valid = enc_any_set & enc_onehot_ok;
`else
   assign target_valid = enc_any_set;
   logic unused_onehot_ok;
   assign unused_onehot_ok = enc_onehot_ok;
`endif

   // Selector bits above the node count carry no meaning.
   if (width > node_contains) begin : g_sel_hi
      logic unused_sel_hi;
      assign unused_sel_hi = ^v_selector[width-1:node_contains];
   end

   // -------------------------------------------------------------------------
   // Holding and decode registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         init_q  <= 1'b0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         if (accept) begin
            sel_q  <= v_selector[node_contains-1:0];
            x_q    <= new_x;
            y_q    <= new_y;
            init_q <= init_en;
         end
         if (state_q == DECODE) begin
            idx_q   <= enc_index;
            valid_q <= target_valid;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Node store
   // -------------------------------------------------------------------------
   // NOTE: the store is flop-based and architecturally visible, and it must
   // read all-zero after reset, so every word is cleared here rather than
   // left to power-up contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < node_contains; n++) begin
            for (int k = 0; k < FIELDS_PER_NODE; k++) begin
               store_q[n][k] <= '0;
            end
         end
      end else if (state_q == WRITE && valid_q) begin
         for (int n = 0; n < node_contains; n++) begin
            if (idx_q == IDX_W'(n)) begin
               store_q[n][FLD_X] <= x_q;
               store_q[n][FLD_Y] <= y_q;
               if (init_q) begin
                  store_q[n][FLD_PRE_X] <= x_q;
                  store_q[n][FLD_PRE_Y] <= y_q;
               end else begin
                  store_q[n][FLD_PRE_X] <= store_q[n][FLD_X];
                  store_q[n][FLD_PRE_Y] <= store_q[n][FLD_Y];
               end
            end
         end
      end
   end

   for (genvar n = 0; n < node_contains; n++) begin : g_node
      for (genvar k = 0; k < FIELDS_PER_NODE; k++) begin : g_fld
         assign ram_flatted[(n*FIELDS_PER_NODE+k)*width +: width] = store_q[n][k];
      end
   end

   // -------------------------------------------------------------------------
   // Completion status
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_done <= 1'b0;
      end else begin
         wr_done <= (state_q == WRITE);
      end
   end

`ifdef CORE_WB_ONEHOT_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_error <= 1'b0;
      end else begin
         wr_error <= (state_q == WRITE) && !valid_q;
      end
   end
`else
   assign wr_error = 1'b0;
`endif

endmodule : core_alu_result_writer

// File: tb/tb_core_alu_result_writer.sv
// ----------------------------------------------------------------------------
// tb_core_alu_result_writer
// Directed, table-driven bench for core_alu_result_writer (width 32, five
// nodes). Inputs change on the falling edge; outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_core_alu_result_writer;

   localparam int W  = 32;
   localparam int NC = 5;
   localparam int NV = 9;

   logic              clk;
   logic              rst_n;
   logic              wr_valid;
   logic              wr_ready;
   logic [W-1:0]      v_selector;
   logic [W-1:0]      new_x;
   logic [W-1:0]      new_y;
   logic              init_en;
   logic [W*4*NC-1:0] ram_flatted;
   logic              wr_done;
   logic              wr_error;
   logic              busy;

   core_alu_result_writer #(
      .width         (W),
      .node_contains (NC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .v_selector  (v_selector),
      .new_x       (new_x),
      .new_y       (new_y),
      .init_en     (init_en),
      .ram_flatted (ram_flatted),
      .wr_done     (wr_done),
      .wr_error    (wr_error),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One vector: inputs, target node (-1: nothing written), that node's
   // expected x, y, pre_x, pre_y after the write, and the expected wr_error.
   typedef struct {
      logic [W-1:0] sel;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         init;
      int           node;
      logic [W-1:0] w0, w1, w2, w3;
      logic         err;
   } vec_t;

   vec_t         vecs [NV];
   logic [W-1:0] exp_mem [NC][4];
   int           errors = 0;
   int           checks = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] word(input int n, input int k);
      return ram_flatted[(n*4+k)*W +: W];
   endfunction

   task automatic check_store(input string tag);
      for (int n = 0; n < NC; n++) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("%s node%0d word%0d", tag, n, k), word(n, k), exp_mem[n][k]);
         end
      end
   endtask

   task automatic clear_exp();
      for (int n = 0; n < NC; n++) begin
         for (int k = 0; k < 4; k++) begin
            exp_mem[n][k] = '0;
         end
      end
   endtask

   task automatic set_node(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
      exp_mem[n][0] = a;
      exp_mem[n][1] = b;
      exp_mem[n][2] = c;
      exp_mem[n][3] = d;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic i);
      wr_valid   = v;
      v_selector = s;
      new_x      = x;
      new_y      = y;
      init_en    = i;
   endtask

   // Called on a falling edge with the DUT idle; returns on the falling edge
   // one cycle after the wr_done pulse.
   task automatic run_vec(input int idx);
      vec_t v;
      string t;
      v = vecs[idx];
      t = $sformatf("vec%0d", idx);
      drive(1'b1, v.sel, v.x, v.y, v.init);
      @(posedge clk);                       // E0: accept
      @(negedge clk);
      drive(1'b0, '0, '0, '0, 1'b0);
      check({t, " busy after accept"}, {31'd0, busy}, 32'd1);
      check({t, " ready after accept"}, {31'd0, wr_ready}, 32'd0);
      @(negedge clk);                       // after E1
      check({t, " done early"}, {31'd0, wr_done}, 32'd0);
      @(negedge clk);                       // after E2
      check({t, " done pulse"}, {31'd0, wr_done}, 32'd1);
      check({t, " error"}, {31'd0, wr_error}, {31'd0, v.err});
      check({t, " ready after commit"}, {31'd0, wr_ready}, 32'd1);
      check({t, " busy after commit"}, {31'd0, busy}, 32'd0);
      if (v.node >= 0) begin
         set_node(v.node, v.w0, v.w1, v.w2, v.w3);
      end
      check_store(t);
      @(negedge clk);
      check({t, " done single cycle"}, {31'd0, wr_done}, 32'd0);
   endtask

   initial begin
      // Hand-computed vectors, applied in order starting from an empty store.
      vecs[0] = '{32'h4, 32'd10, 32'd20, 1'b1, 2, 32'd10, 32'd20, 32'd10, 32'd20, 1'b0};
      vecs[1] = '{32'h4, 32'd11, 32'd22, 1'b0, 2, 32'd11, 32'd22, 32'd10, 32'd20, 1'b0};
      vecs[2] = '{32'h1, 32'd5,  32'd6,  1'b1, 0, 32'd5,  32'd6,  32'd5,  32'd6,  1'b0};
      vecs[3] = '{32'h1, 32'd7,  32'd9,  1'b0, 0, 32'd7,  32'd9,  32'd5,  32'd6,  1'b0};
`ifdef CORE_WB_ONEHOT_CHECK_EN
      vecs[4] = '{32'h0,  32'd99, 32'd99, 1'b0, -1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1};
      vecs[5] = '{32'h20, 32'd99, 32'd99, 1'b1, -1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1};
      vecs[6] = '{32'h6,  32'd7,  32'd8,  1'b0, -1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1};
`else
      vecs[4] = '{32'h0,  32'd99, 32'd99, 1'b0, -1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
      vecs[5] = '{32'h20, 32'd99, 32'd99, 1'b1, -1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
      vecs[6] = '{32'h6,  32'd7,  32'd8,  1'b0, 1,  32'd7, 32'd8, 32'd0, 32'd0, 1'b0};
`endif
      // High selector bits ignored: only bit 4 is set in the low five bits.
      vecs[7] = '{32'hFFFF_FF10, 32'h1234, 32'h5678, 1'b1, 4,
                  32'h1234, 32'h5678, 32'h1234, 32'h5678, 1'b0};
      vecs[8] = '{32'h8, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 3,
                  32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 1'b0};

      clear_exp();
      rst_n = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0);

      // ---------------- reset state ----------------
      @(negedge clk);
      check("reset ready", {31'd0, wr_ready}, 32'd1);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, wr_done}, 32'd0);
      check("reset error", {31'd0, wr_error}, 32'd0);
      check_store("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < NV; i++) begin
         run_vec(i);
      end

      // ---------------- back-to-back with wr_valid held ----------------
      // First result is captured at E0; inputs change while busy, and the
      // second accept must land exactly on E3 with the changed inputs.
`ifdef CORE_WB_ONEHOT_CHECK_EN
      // node 1 untouched by the rejected 0x6 vector
`else
      // node 1 holds 7, 8, 0, 0 from the 0x6 vector
`endif
      drive(1'b1, 32'h2, 32'd100, 32'd200, 1'b1);
      @(posedge clk);                       // E0
      @(negedge clk);
      drive(1'b1, 32'h2, 32'd300, 32'd400, 1'b0);
      check("b2b busy first", {31'd0, busy}, 32'd1);
      @(negedge clk);
      @(negedge clk);                       // after E2
      check("b2b done first", {31'd0, wr_done}, 32'd1);
      check("b2b idle before E3", {31'd0, busy}, 32'd0);
      set_node(1, 32'd100, 32'd200, 32'd100, 32'd200);
      check_store("b2b first");
      @(negedge clk);                       // after E3
      drive(1'b0, '0, '0, '0, 1'b0);
      check("b2b second accepted at E3", {31'd0, busy}, 32'd1);
      check("b2b done cleared", {31'd0, wr_done}, 32'd0);
      @(negedge clk);
      @(negedge clk);                       // after E5
      check("b2b done second", {31'd0, wr_done}, 32'd1);
      set_node(1, 32'd300, 32'd400, 32'd100, 32'd200);
      check_store("b2b second");
      @(negedge clk);

      // ---------------- wr_valid pulses in DECODE/WRITE ignored ----------------
      drive(1'b1, 32'h8, 32'd1, 32'd2, 1'b0);
      @(posedge clk);                       // E0
      @(negedge clk);                       // in DECODE
      drive(1'b1, 32'h1, 32'hDEAD, 32'hBEEF, 1'b1);
      @(negedge clk);                       // in WRITE
      drive(1'b1, 32'h1, 32'hCAFE, 32'hF00D, 1'b1);
      @(negedge clk);                       // after E2, back in IDLE
      drive(1'b0, '0, '0, '0, 1'b0);
      check("ignore done", {31'd0, wr_done}, 32'd1);
      set_node(3, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000);
      check_store("ignore");
      @(negedge clk);
      check("ignore no extra accept", {31'd0, busy}, 32'd0);
      check("ignore done single", {31'd0, wr_done}, 32'd0);
      check_store("ignore after");

      // ---------------- reset in the middle of DECODE ----------------
      drive(1'b1, 32'h4, 32'd55, 32'd66, 1'b1);
      @(posedge clk);                       // E0
      @(negedge clk);                       // in DECODE
      drive(1'b0, '0, '0, '0, 1'b0);
      check("midrst busy before", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst ready", {31'd0, wr_ready}, 32'd1);
      clear_exp();
      check_store("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int pulses;
         pulses = 0;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (wr_done) pulses++;
         end
         check("midrst no done", pulses, 32'd0);
      end
      check_store("midrst after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_core_alu_result_writer
